// File: rtl/spi_reg_pkg.sv
// Shared types and defaults for the SPI register path (slave front end, bridge, register bank).
package spi_reg_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 16;
  localparam logic [15:0] DEF_ERR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2
  } bridge_state_t;

  // One extra bit so the terminal count is reachable without wrap-around.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/spi_reg_bridge_edge_sync.sv
// Multi-flop synchroniser for an SCLK-domain strobe, followed by a registered rising-edge pulse.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);

  logic [STAGES-1:0] sync;
  logic              dly;

  // Shift chain, delay flop and one-cycle pulse on each 0->1 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      dly  <= 1'b0;
      evt  <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      dly  <= sync[STAGES-1];
      evt  <= sync[STAGES-1] & ~dly;
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// Carries decoded SPI read/write transactions into the clk domain as single-beat register bus requests.
module spi_reg_bridge import spi_reg_pkg::*; #(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter int                TIMEOUT_CYC = 8,
  parameter logic [DATA_W-1:0] ERR_DATA    = DEF_ERR_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rd_en_stretch,
  input  logic              wr_en_stretch,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_rd_en,
  output logic              reg_wr_en,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_collision,
  input  logic              err_clr
);

  localparam int             CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  bridge_state_t     state;
  logic [CNT_W-1:0]  cnt;
  logic              rd_evt;
  logic              wr_evt;
  logic              wr_pending;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              timeout_hit;
  logic              collision;

  edge_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (.clk(clk), .rst(rst), .din(rd_en_stretch), .evt(rd_evt));
  edge_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (.clk(clk), .rst(rst), .din(wr_en_stretch), .evt(wr_evt));

  // A late ack wins over the timeout; a read or a second write arriving while busy is lost.
  always_comb begin
    timeout_hit = 1'b0;
    collision   = 1'b0;
    if (state != IDLE) begin
      timeout_hit = ~reg_ack && (cnt == TMO_LAST);
      collision   = rd_evt || (wr_evt && wr_pending);
    end else begin
      collision   = rd_evt && wr_evt && wr_pending;
    end
  end

  // Request FSM: read has priority in IDLE because MISO needs its data before the next SCLK edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      reg_rd_en  <= 1'b0;
      reg_wr_en  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      tx_data    <= '0;
      wr_pending <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rd_evt) begin
            state     <= RD_REQ;
            reg_rd_en <= 1'b1;
            reg_addr  <= rx_addr;
            if (wr_evt && !wr_pending) begin
              wr_pending <= 1'b1;
              wr_addr_q  <= rx_addr;
              wr_data_q  <= rx_data;
            end
          end else if (wr_pending) begin
            state     <= WR_REQ;
            reg_wr_en <= 1'b1;
            reg_addr  <= wr_addr_q;
            reg_wdata <= wr_data_q;
            if (wr_evt) begin
              wr_addr_q <= rx_addr;
              wr_data_q <= rx_data;
            end else begin
              wr_pending <= 1'b0;
            end
          end else if (wr_evt) begin
            state     <= WR_REQ;
            reg_wr_en <= 1'b1;
            reg_addr  <= rx_addr;
            reg_wdata <= rx_data;
          end
        end
        RD_REQ, WR_REQ: begin
          if (wr_evt && !wr_pending) begin
            wr_pending <= 1'b1;
            wr_addr_q  <= rx_addr;
            wr_data_q  <= rx_data;
          end
          if (reg_ack || timeout_hit) begin
            state     <= IDLE;
            reg_rd_en <= 1'b0;
            reg_wr_en <= 1'b0;
            if (state == RD_REQ) begin
              tx_data <= reg_ack ? reg_rdata : ERR_DATA;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          reg_rd_en <= 1'b0;
          reg_wr_en <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle outranks err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout   <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
      if (collision) begin
        err_collision <= 1'b1;
      end else if (err_clr) begin
        err_collision <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) | wr_pending;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed and randomized transactions against a transaction-level memory model of the register bank.
module tb_spi_reg_bridge;

  localparam int AW  = 14;
  localparam int DW  = 16;
  localparam int LAT = 4;   // SYNC_STAGES + 2
  localparam int TMO = 8;
  localparam logic [DW-1:0] ERRV = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rx_addr;
  logic [DW-1:0] rx_data;
  logic          rd_en_stretch;
  logic          wr_en_stretch;
  logic [DW-1:0] tx_data;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_rd_en;
  logic          reg_wr_en;
  logic [DW-1:0] reg_rdata;
  logic          reg_ack;
  logic          busy;
  logic          err_timeout;
  logic          err_collision;
  logic          err_clr;

  spi_reg_bridge dut (
    .clk(clk), .rst(rst), .rx_addr(rx_addr), .rx_data(rx_data),
    .rd_en_stretch(rd_en_stretch), .wr_en_stretch(wr_en_stretch), .tx_data(tx_data),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy), .err_timeout(err_timeout),
    .err_collision(err_collision), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] bank_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem  [0:(1<<AW)-1];
  logic [DW-1:0] exp_tx;
  logic          exp_tmo;
  logic          exp_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input bit wr, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      seen = wr ? reg_wr_en : reg_rd_en;
    end
    chk("req_seen", 32'(seen), 32'd1);
  endtask

  // Act as the register bank: ack after d extra cycles (d < 0: never), return cycles the request was high.
  task automatic serve(input bit wr, input int d, output int high);
    bit req;
    req = 1'b1;
    high = 0;
    while (req && high < 40) begin
      high++;
      if (high - 1 == d) begin
        reg_ack   = 1'b1;
        reg_rdata = bank_mem[reg_addr];
        if (wr) bank_mem[reg_addr] = reg_wdata;
      end
      @(negedge clk);
      reg_ack = 1'b0;
      req = wr ? reg_wr_en : reg_rd_en;
    end
  endtask

  task automatic xact(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input int d, input int hold);
    int cyc;
    int high;
    rx_addr = addr;
    rx_data = data;
    if (wr) wr_en_stretch = 1'b1; else rd_en_stretch = 1'b1;
    wait_req(wr, cyc);
    chk("latency", 32'(cyc), 32'(LAT));
    chk("reg_addr", 32'(reg_addr), 32'(addr));
    if (wr) chk("reg_wdata", 32'(reg_wdata), 32'(data));
    serve(wr, d, high);
    chk("req_cycles", 32'(high), 32'(d < 0 ? TMO : d + 1));
    if (d < 0) exp_tmo = 1'b1;
    else if (wr) exp_mem[addr] = data;
    if (!wr) exp_tx = (d < 0) ? ERRV : exp_mem[addr];
    chk("tx_data", 32'(tx_data), 32'(exp_tx));
    chk("busy", 32'(busy), 32'd0);
    chk("err_timeout", 32'(err_timeout), 32'(exp_tmo));
    chk("err_collision", 32'(err_collision), 32'(exp_col));
    repeat (hold) @(negedge clk);
    chk("no_retrigger", 32'(reg_rd_en | reg_wr_en), 32'd0);
    rd_en_stretch = 1'b0;
    wr_en_stretch = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int cyc;
    int high;
    bit rd_seen;
    bit wr;
    int d;
    logic [AW-1:0] a;
    logic [DW-1:0] v;

    for (int i = 0; i < (1 << AW); i++) begin
      bank_mem[i] = 16'(i * 7 + 3);
      exp_mem[i]  = 16'(i * 7 + 3);
    end
    bank_mem[14'h0012] = 16'hA5C3;
    exp_mem[14'h0012]  = 16'hA5C3;
    exp_tx = '0; exp_tmo = 1'b0; exp_col = 1'b0;

    rst = 1'b1; rx_addr = '0; rx_data = '0; rd_en_stretch = 1'b0; wr_en_stretch = 1'b0;
    reg_rdata = '0; reg_ack = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_req", 32'({reg_rd_en, reg_wr_en}), 32'd0);
    chk("rst_addr_wdata", 32'({reg_addr, reg_wdata}), 32'd0);
    chk("rst_busy_flags", 32'({busy, err_timeout, err_collision}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic read, strobe held about 20 clk
    xact(1'b0, 14'h0012, 16'h0000, 0, 14);
    // 2: write with ack on the third request cycle, tx_data untouched
    xact(1'b1, 14'h0100, 16'h1234, 2, 0);
    // 3: read timeout, then err_clr
    xact(1'b0, 14'h0040, 16'h0000, -1, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_tmo = 1'b0;
    chk("err_clr_timeout", 32'(err_timeout), 32'd0);

    // 4: simultaneous read and write strobes
    rx_addr = 14'h0003; rx_data = 16'hBEEF;
    rd_en_stretch = 1'b1; wr_en_stretch = 1'b1;
    wait_req(1'b0, cyc);
    chk("both_rd_latency", 32'(cyc), 32'(LAT));
    chk("both_rd_first", 32'({reg_rd_en, reg_wr_en}), 32'd2);
    chk("both_rd_addr", 32'(reg_addr), 32'h3);
    serve(1'b0, 0, high);
    exp_tx = exp_mem[3];
    chk("both_rd_tx", 32'(tx_data), 32'(exp_tx));
    chk("both_pending_busy", 32'(busy), 32'd1);
    wait_req(1'b1, cyc);
    chk("both_wr_latency", 32'(cyc), 32'd1);
    chk("both_wr_addr", 32'(reg_addr), 32'h3);
    chk("both_wr_data", 32'(reg_wdata), 32'hBEEF);
    serve(1'b1, 1, high);
    exp_mem[3] = 16'hBEEF;
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_no_collision", 32'(err_collision), 32'd0);
    rd_en_stretch = 1'b0; wr_en_stretch = 1'b0;
    repeat (4) @(negedge clk);
    xact(1'b0, 14'h0003, 16'h0000, 0, 0);

    // 5: read strobe while a write is waiting for ack
    rx_addr = 14'h0200; rx_data = 16'h55AA;
    wr_en_stretch = 1'b1;
    wait_req(1'b1, cyc);
    rd_en_stretch = 1'b1;
    serve(1'b1, 5, high);
    exp_mem[14'h0200] = 16'h55AA;
    exp_col = 1'b1;
    chk("col_wr_cycles", 32'(high), 32'd6);
    chk("col_flag", 32'(err_collision), 32'd1);
    chk("col_busy", 32'(busy), 32'd0);
    rd_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      rd_seen = rd_seen | reg_rd_en;
    end
    chk("col_read_dropped", 32'(rd_seen), 32'd0);
    rd_en_stretch = 1'b0; wr_en_stretch = 1'b0;
    repeat (4) @(negedge clk);

    // 6: reset in the middle of a read request
    rx_addr = 14'h0007;
    rd_en_stretch = 1'b1;
    wait_req(1'b0, cyc);
    @(negedge clk);
    rst = 1'b1; rd_en_stretch = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_tx = '0; exp_tmo = 1'b0; exp_col = 1'b0;
    chk("midrst_rd_en", 32'(reg_rd_en), 32'd0);
    chk("midrst_tx", 32'(tx_data), 32'd0);
    chk("midrst_busy_flags", 32'({busy, err_timeout, err_collision}), 32'd0);
    repeat (4) @(negedge clk);
    xact(1'b0, 14'h0007, 16'h0000, 1, 0);

    // randomized traffic over a small address window so reads observe earlier writes
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 14'($urandom_range(0, 7));
      v  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d = -1;
      else d = int'($urandom_range(0, 3));
      xact(wr, a, v, d, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
Sits directly downstream of the SPI slave front end and carries its decoded transactions into the `clk` domain.
- Synchronises the SCLK-domain `rd_en_stretch` / `wr_en_stretch` pulses and detects their rising edges.
- Captures the held `rx_addr` / `rx_data`.
- Issues single-beat read/write requests on the internal register bus with a req/ack handshake.
- Returns read data on `tx_data` for MISO shift-out, with timeout and collision handling.

Parameters:
- ADDR_W, 14, register address width (matches SPI address field)
- DATA_W, 16, register data width
- SYNC_STAGES, 2, flops in each enable synchroniser (min 2)
- TIMEOUT_CYC, 8, clk cycles to wait for reg_ack before abort
- ERR_DATA, 16'hDEAD, value driven on tx_data after a read timeout

Ports:
- clk  in  1  system clock (≥10x SCLK)
- rst  in  1  synchronous active-high reset
- rx_addr  in  ADDR_W  address from SPI slave; stable ≥2 SCLK periods after enable
- rx_data  in  DATA_W  write data from SPI slave; stable ≥2 SCLK periods after enable
- rd_en_stretch  in  1  SCLK-domain read strobe, 2 SCLK periods wide
- wr_en_stretch  in  1  SCLK-domain write strobe, 2 SCLK periods wide
- tx_data  out  DATA_W  read data back to SPI slave
- reg_addr  out  ADDR_W  register bus address
- reg_wdata  out  DATA_W  register bus write data
- reg_rd_en  out  1  read request, held until ack/timeout
- reg_wr_en  out  1  write request, held until ack/timeout
- reg_rdata  in  DATA_W  read data, valid with reg_ack
- reg_ack  in  1  one-cycle completion from register bank
- busy  out  1  FSM not IDLE or write pending
- err_timeout  out  1  sticky: a request timed out
- err_collision  out  1  sticky: new strobe arrived while busy
- err_clr  in  1  clears both sticky error flags

Behaviour:
- **Reset** (sync, rst=1 at posedge clk): all outputs 0, FSM=IDLE, synchronisers 0, timeout counter 0, wr_pending 0. tx_data=0.
- **Synchronisers**: each strobe passes SYNC_STAGES flops plus one delay flop.
  - rd_evt = sync & ~dly; wr_evt likewise.
  - Each event is a one-cycle pulse per SPI transaction.
- **Capture**: on rd_evt, latch rx_addr into reg_addr. On wr_evt, latch rx_addr into reg_addr and rx_data into reg_wdata. These inputs are already stable, so no further sync is needed.
- **FSM states**: IDLE, RD_REQ, WR_REQ.
  - IDLE + rd_evt → RD_REQ, reg_rd_en=1 next cycle.
  - IDLE + wr_evt → WR_REQ, reg_wr_en=1 next cycle.
  - IDLE + wr_pending → WR_REQ using the buffered address/data.
- **RD_REQ**:
  - reg_ack → tx_data<=reg_rdata, reg_rd_en=0, back to IDLE.
  - Counter reaches TIMEOUT_CYC-1 without ack → tx_data<=ERR_DATA, err_timeout=1, back to IDLE.
- **WR_REQ**: same rules; a timeout leaves tx_data unchanged.
- **Latency**: read strobe edge at the sync input to reg_rd_en = SYNC_STAGES+2 clk. ack to tx_data valid = 1 clk. At 10x SCLK with reg_ack within 1 cycle, tx_data is ready before the next SCLK negedge.
- **Timeout counter**: resets to 0 on entering a REQ state. Width is ceil(log2(TIMEOUT_CYC))+1, and it saturates.
- **Simultaneous rd_evt and wr_evt in IDLE**:
  - Read wins (it has an MISO deadline).
  - The write's address and data are buffered in a separate wr_addr_q / wr_data_q; wr_pending=1.
  - The write is serviced on the next IDLE.
  - reg_addr/reg_wdata are loaded from the buffer on WR_REQ entry.
- **Event while in a REQ state**:
  - A write event is buffered if wr_pending=0; otherwise it is dropped and err_collision=1.
  - A read event is dropped and err_collision=1.
- **Ack handling**: reg_ack while IDLE is ignored. Ack in the same cycle as the timeout is treated as success.
- **err_clr vs new error**: err_clr has lower priority than a new error in the same cycle.
- **tx_data retention**: holds its value until the next read completes.
- **busy** = (state!=IDLE) | wr_pending.
- **rst mid-request**: request deasserts the next cycle, the pending write is discarded, and flags clear.

Decomposition:
- Package spi_reg_pkg holds:
  - the state enum typedef bridge_state_t {IDLE, RD_REQ, WR_REQ};
  - ADDR_W/DATA_W defaults and ERR_DATA;
  - shared with spi_slave and the regbank.
- Sub-module edge_sync: SYNC_STAGES-flop synchroniser plus rising-edge pulse, instantiated twice.

Test Plan:
1. Read: rx_addr=14'h0012, rd_en_stretch high 20 clk, reg_ack at 1st request cycle with reg_rdata=16'hA5C3 → reg_rd_en single cycle at edge+4, reg_addr=0x0012, tx_data=16'hA5C3 one cycle later, busy returns 0.
2. Write: rx_addr=14'h0100, rx_data=16'h1234, wr_en_stretch pulse, ack after 3 cycles → reg_wr_en high exactly 3 cycles, reg_addr=0x0100, reg_wdata=0x1234, tx_data unchanged.
3. Read timeout: no ack, TIMEOUT_CYC=8 → reg_rd_en high 8 cycles then 0, tx_data=16'hDEAD, err_timeout=1; err_clr pulse clears it.
4. Collision: rd_en_stretch and wr_en_stretch rise in the same clk (addr 0x0003, data 0xBEEF) → read serviced first, then write with reg_addr=0x0003, reg_wdata=0xBEEF; err_collision stays 0.
5. Read strobe during WR_REQ (ack withheld) → read dropped, err_collision=1, write completes normally on ack.
6. rst asserted during RD_REQ → next clk: reg_rd_en=0, tx_data=0, busy=0, flags 0; a subsequent read works normally.
